// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: five prioritised sources, programmable FIFO thresholds,
// character-timeout counter and sticky pending flags feeding a registered IIR.
module uart_irq_ctrl #(
    parameter int unsigned TX_FIFO_DEPTH = 32,
    parameter int unsigned RX_FIFO_DEPTH = 32,
    parameter int unsigned TIMEOUT_CHARS = 4,
    localparam int unsigned TXW = $clog2(TX_FIFO_DEPTH) + 1,
    localparam int unsigned RXW = $clog2(RX_FIFO_DEPTH) + 1
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic [4:0]     ier_i,
    input  logic [RXW-1:0] rx_trigger_i,
    input  logic [TXW-1:0] tx_trigger_i,
    input  logic [RXW-1:0] rx_elements_i,
    input  logic [TXW-1:0] tx_elements_i,
    input  logic           rx_push_i,
    input  logic           rx_pop_i,
    input  logic           tx_push_i,
    input  logic           char_tick_i,
    input  logic           error_i,
    input  logic           msr_change_i,
    input  logic           iir_rd_i,
    input  logic           lsr_rd_i,
    input  logic           msr_rd_i,
    output logic [4:0]     pending_o,
    output logic [3:0]     iir_o,
    output logic           interrupt_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CHARS + 1);
    localparam logic [CW-1:0] TimeoutCnt = CW'(TIMEOUT_CHARS);

    localparam int unsigned BitRda  = 0;
    localparam int unsigned BitThre = 1;
    localparam int unsigned BitLsi  = 2;
    localparam int unsigned BitCti  = 3;
    localparam int unsigned BitMsi  = 4;

    logic [4:0]    pending_q, pending_d;
    logic [3:0]    iir_q, iir_d;
    logic          irq_q, irq_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cond_q, ier_thre_q;

    logic [RXW-1:0] rx_thr;
    logic           cond;
    logic           thre_set;
    logic           thre_rd_clr;
    logic [4:0]     masked;

    assign rx_thr = (rx_trigger_i == '0) ? RXW'(1) : rx_trigger_i;
    assign cond   = (tx_elements_i <= tx_trigger_i);

    // THRE arms on a fresh threshold crossing, or when re-enabled while already below it.
    assign thre_set    = (cond & ~cond_q) | (ier_i[BitThre] & ~ier_thre_q & cond);
    assign thre_rd_clr = iir_rd_i & (iir_q == 4'b0010);

    always_comb begin
        cnt_d = cnt_q;
        if (rx_push_i || rx_pop_i || (rx_elements_i == '0)) begin
            cnt_d = '0;
        end else if (char_tick_i && (cnt_q != TimeoutCnt)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        pending_d = pending_q;

        pending_d[BitRda] = (rx_elements_i >= rx_thr);
        pending_d[BitCti] = (cnt_d == TimeoutCnt) && (rx_elements_i != '0);
        pending_d[BitLsi] = error_i | (pending_q[BitLsi] & ~lsr_rd_i);
        pending_d[BitMsi] = msr_change_i | (pending_q[BitMsi] & ~msr_rd_i);

        if (tx_push_i) begin
            pending_d[BitThre] = 1'b0;
        end else if (thre_set) begin
            pending_d[BitThre] = 1'b1;
        end else if (thre_rd_clr) begin
            pending_d[BitThre] = 1'b0;
        end
    end

    always_comb begin
        masked = pending_d & ier_i;
        iir_d  = 4'b0001;
        if (masked[BitLsi]) begin
            iir_d = 4'b0110;
        end else if (masked[BitRda]) begin
            iir_d = 4'b0100;
        end else if (masked[BitCti]) begin
            iir_d = 4'b1100;
        end else if (masked[BitThre]) begin
            iir_d = 4'b0010;
        end else if (masked[BitMsi]) begin
            iir_d = 4'b0000;
        end
        irq_d = ~iir_d[0];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending_q  <= '0;
            iir_q      <= 4'b0001;
            irq_q      <= 1'b0;
            cnt_q      <= '0;
            cond_q     <= 1'b0;
            ier_thre_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            iir_q      <= iir_d;
            irq_q      <= irq_d;
            cnt_q      <= cnt_d;
            cond_q     <= cond;
            ier_thre_q <= ier_i[BitThre];
        end
    end

    assign pending_o   = pending_q;
    assign iir_o       = iir_q;
    assign interrupt_o = irq_q;

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Directed self-checking bench for uart_irq_ctrl with default parameters.
module tb_uart_irq_ctrl;

    localparam int unsigned TXW = 6;
    localparam int unsigned RXW = 6;

    logic           clk_i = 1'b0;
    logic           rstn_i = 1'b1;
    logic [4:0]     ier_i = '0;
    logic [RXW-1:0] rx_trigger_i = '0;
    logic [TXW-1:0] tx_trigger_i = '0;
    logic [RXW-1:0] rx_elements_i = '0;
    logic [TXW-1:0] tx_elements_i = '0;
    logic           rx_push_i = 1'b0;
    logic           rx_pop_i = 1'b0;
    logic           tx_push_i = 1'b0;
    logic           char_tick_i = 1'b0;
    logic           error_i = 1'b0;
    logic           msr_change_i = 1'b0;
    logic           iir_rd_i = 1'b0;
    logic           lsr_rd_i = 1'b0;
    logic           msr_rd_i = 1'b0;
    logic [4:0]     pending_o;
    logic [3:0]     iir_o;
    logic           interrupt_o;

    int tests = 0;
    int fails = 0;

    uart_irq_ctrl dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .ier_i         (ier_i),
        .rx_trigger_i  (rx_trigger_i),
        .tx_trigger_i  (tx_trigger_i),
        .rx_elements_i (rx_elements_i),
        .tx_elements_i (tx_elements_i),
        .rx_push_i     (rx_push_i),
        .rx_pop_i      (rx_pop_i),
        .tx_push_i     (tx_push_i),
        .char_tick_i   (char_tick_i),
        .error_i       (error_i),
        .msr_change_i  (msr_change_i),
        .iir_rd_i      (iir_rd_i),
        .lsr_rd_i      (lsr_rd_i),
        .msr_rd_i      (msr_rd_i),
        .pending_o     (pending_o),
        .iir_o         (iir_o),
        .interrupt_o   (interrupt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        char_tick_i = 1'b1;
        step();
        char_tick_i = 1'b0;
    endtask

    initial begin
        tx_elements_i = 6'd5;
        #2 rstn_i = 1'b0;
        #1;
        chk("rst_pending", 8'(pending_o), 8'h00);
        chk("rst_iir", 8'(iir_o), 8'h01);
        chk("rst_irq", 8'(interrupt_o), 8'h00);
        step();
        step();
        rstn_i = 1'b1;
        step();
        chk("idle_pending", 8'(pending_o), 8'h00);

        // THRE: enable together with FIFO drained below threshold
        ier_i = 5'b00010;
        tx_elements_i = '0;
        step();
        chk("thre_iir", 8'(iir_o), 8'h02);
        chk("thre_irq", 8'(interrupt_o), 8'h01);
        iir_rd_i = 1'b1;
        step();
        iir_rd_i = 1'b0;
        chk("thre_iir_rd", 8'(iir_o), 8'h01);
        tx_push_i = 1'b1;
        tx_elements_i = 6'd1;
        step();
        tx_push_i = 1'b0;
        chk("thre_push", 8'(pending_o), 8'h00);
        tx_elements_i = '0;
        step();
        chk("thre_reset_again", 8'(iir_o), 8'h02);
        ier_i = '0;
        step();
        chk("thre_masked_iir", 8'(iir_o), 8'h01);
        chk("thre_masked_pend", 8'(pending_o), 8'h02);
        tx_push_i = 1'b1;
        step();
        tx_push_i = 1'b0;
        chk("thre_clr_level", 8'(pending_o), 8'h00);
        ier_i = 5'b00010;
        step();
        chk("thre_rearm", 8'(iir_o), 8'h02);
        ier_i = '0;

        // RDA threshold
        ier_i = 5'b00001;
        rx_trigger_i = 6'd8;
        for (int i = 1; i <= 7; i++) begin
            rx_push_i = 1'b1;
            rx_elements_i = RXW'(i);
            step();
        end
        rx_push_i = 1'b0;
        chk("rda_below", 8'(iir_o), 8'h01);
        rx_push_i = 1'b1;
        rx_elements_i = 6'd8;
        step();
        rx_push_i = 1'b0;
        chk("rda_at", 8'(iir_o), 8'h04);
        rx_pop_i = 1'b1;
        rx_elements_i = 6'd7;
        step();
        rx_pop_i = 1'b0;
        chk("rda_pop", 8'(iir_o), 8'h01);
        rx_trigger_i = '0;
        rx_elements_i = '0;
        step();
        chk("rda_trig0_empty", 8'(pending_o), 8'h02);
        rx_elements_i = 6'd1;
        step();
        chk("rda_trig0_one", 8'(pending_o), 8'h03);
        rx_trigger_i = 6'd8;

        // Priority: LSI over RDA over THRE
        ier_i = 5'b11111;
        rx_elements_i = 6'd8;
        step();
        chk("prio_rda", 8'(iir_o), 8'h04);
        error_i = 1'b1;
        step();
        error_i = 1'b0;
        chk("prio_lsi", 8'(iir_o), 8'h06);
        chk("prio_pend", 8'(pending_o), 8'h07);
        lsr_rd_i = 1'b1;
        step();
        lsr_rd_i = 1'b0;
        chk("lsr_rd", 8'(iir_o), 8'h04);
        rx_elements_i = '0;
        step();
        chk("prio_thre", 8'(iir_o), 8'h02);
        msr_change_i = 1'b1;
        step();
        msr_change_i = 1'b0;
        chk("msi_under_thre", 8'(iir_o), 8'h02);
        chk("msi_pend", 8'(pending_o), 8'h12);
        msr_change_i = 1'b1;
        msr_rd_i = 1'b1;
        step();
        msr_change_i = 1'b0;
        msr_rd_i = 1'b0;
        chk("msi_set_wins", 8'(pending_o), 8'h12);
        msr_rd_i = 1'b1;
        step();
        msr_rd_i = 1'b0;
        chk("msi_clr", 8'(pending_o), 8'h02);

        // Character timeout
        ier_i = 5'b01000;
        rx_elements_i = 6'd2;
        step();
        tick();
        tick();
        tick();
        chk("cti_3", 8'(iir_o), 8'h01);
        tick();
        chk("cti_4", 8'(iir_o), 8'h0c);
        chk("cti_irq", 8'(interrupt_o), 8'h01);
        rx_pop_i = 1'b1;
        rx_elements_i = 6'd1;
        step();
        rx_pop_i = 1'b0;
        chk("cti_pop", 8'(iir_o), 8'h01);
        tick();
        tick();
        tick();
        chk("cti_restart_3", 8'(iir_o), 8'h01);
        tick();
        chk("cti_restart_4", 8'(iir_o), 8'h0c);
        tick();
        chk("cti_saturate", 8'(iir_o), 8'h0c);
        rx_elements_i = '0;
        step();
        chk("cti_empty", 8'(pending_o), 8'h02);

        // Same-cycle set/clear races
        ier_i = 5'b00100;
        error_i = 1'b1;
        lsr_rd_i = 1'b1;
        step();
        error_i = 1'b0;
        lsr_rd_i = 1'b0;
        chk("lsi_set_wins", 8'(iir_o), 8'h06);
        lsr_rd_i = 1'b1;
        step();
        lsr_rd_i = 1'b0;
        chk("lsi_clr", 8'(iir_o), 8'h01);
        tx_push_i = 1'b1;
        tx_elements_i = 6'd3;
        step();
        chk("thre_push_clr", 8'(pending_o), 8'h00);
        tx_elements_i = '0;
        step();
        tx_push_i = 1'b0;
        chk("thre_push_beats_set", 8'(pending_o), 8'h00);
        step();
        chk("thre_no_late_set", 8'(pending_o), 8'h00);

        // MSI alone, then asynchronous reset mid-operation
        ier_i = 5'b10000;
        msr_change_i = 1'b1;
        step();
        msr_change_i = 1'b0;
        chk("msi_iir", 8'(iir_o), 8'h00);
        chk("msi_irq", 8'(interrupt_o), 8'h01);
        rx_elements_i = 6'd2;
        tick();
        tick();
        #2 rstn_i = 1'b0;
        #1;
        chk("arst_iir", 8'(iir_o), 8'h01);
        chk("arst_pending", 8'(pending_o), 8'h00);
        chk("arst_irq", 8'(interrupt_o), 8'h00);
        step();
        rstn_i = 1'b1;
        ier_i = 5'b01000;
        step();
        tick();
        tick();
        tick();
        chk("arst_cnt_3", 8'(iir_o), 8'h01);
        tick();
        chk("arst_cnt_4", 8'(iir_o), 8'h0c);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
